// File: rtl/hci_mem_req_slice.sv
// Registered request/response cut for an HCI memory port: 2-entry skid buffer on the
// request path, 1-cycle response tagging with an optional extra response register stage.
module hci_mem_req_slice #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned BW       = 8,
  parameter int unsigned IW       = 8,
  parameter int unsigned UW       = 1,
  parameter int unsigned RESP_REG = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  output logic               busy_o,
  input  logic               slave_req_i,
  output logic               slave_gnt_o,
  input  logic [AW-1:0]      slave_add_i,
  input  logic               slave_we_n_i,
  input  logic [DW-1:0]      slave_data_i,
  input  logic [DW/BW-1:0]   slave_be_i,
  input  logic [IW-1:0]      slave_id_i,
  input  logic [UW-1:0]      slave_user_i,
  output logic [DW-1:0]      slave_r_data_o,
  output logic [IW-1:0]      slave_r_id_o,
  output logic [UW-1:0]      slave_r_user_o,
  output logic               slave_r_valid_o,
  output logic               master_req_o,
  input  logic               master_gnt_i,
  output logic [AW-1:0]      master_add_o,
  output logic               master_we_n_o,
  output logic [DW-1:0]      master_data_o,
  output logic [DW/BW-1:0]   master_be_o,
  output logic [IW-1:0]      master_id_o,
  output logic [UW-1:0]      master_user_o,
  input  logic [DW-1:0]      master_r_data_i,
  input  logic [IW-1:0]      master_r_id_i,
  input  logic [UW-1:0]      master_r_user_i
);

  localparam int unsigned BEW = DW / BW;

  typedef struct packed {
    logic [AW-1:0]  add;
    logic           we_n;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
    logic [IW-1:0]  id;
    logic [UW-1:0]  user;
  } req_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e state_q, state_d;
  req_t   head_q, head_d, skid_q, skid_d, in_req;
  logic   gnt_q, gnt_d, req_q, req_d, busy_q, busy_d;
  logic   push, pop;
  logic   rvalid_q, rvalid_mid;

  assign in_req = '{add: slave_add_i, we_n: slave_we_n_i, data: slave_data_i,
                    be: slave_be_i, id: slave_id_i, user: slave_user_i};

  // clear_i masks both handshakes in its own cycle
  assign slave_gnt_o  = gnt_q & ~clear_i;
  assign master_req_o = req_q & ~clear_i;
  assign push         = slave_req_i & slave_gnt_o;
  assign pop          = master_req_o & master_gnt_i;

  assign master_add_o  = head_q.add;
  assign master_we_n_o = head_q.we_n;
  assign master_data_o = head_q.data;
  assign master_be_o   = head_q.be;
  assign master_id_o   = head_q.id;
  assign master_user_o = head_q.user;
  assign busy_o        = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      gnt_q    <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      gnt_q    <= gnt_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      rvalid_q <= pop;
    end
  end

  // Head always drives the master port; skid only fills when head is stalled
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_req;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_req;
        end else if (push) begin
          skid_d  = in_req;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clear_i) state_d = EMPTY;
    gnt_d  = (state_d != TWO);
    req_d  = (state_d != EMPTY);
    busy_d = req_d | pop | rvalid_mid;
  end

  generate
    if (RESP_REG != 0) begin : g_resp_reg
      logic          rvalid2_q;
      logic [DW-1:0] r_data_q;
      logic [IW-1:0] r_id_q;
      logic [UW-1:0] r_user_q;

      // Response fields capture only on a valid beat and hold otherwise
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rvalid2_q <= 1'b0;
          r_data_q  <= '0;
          r_id_q    <= '0;
          r_user_q  <= '0;
        end else begin
          rvalid2_q <= rvalid_q;
          if (rvalid_q) begin
            r_data_q <= master_r_data_i;
            r_id_q   <= master_r_id_i;
            r_user_q <= master_r_user_i;
          end
        end
      end

      assign rvalid_mid      = rvalid_q;
      assign slave_r_valid_o = rvalid2_q;
      assign slave_r_data_o  = r_data_q;
      assign slave_r_id_o    = r_id_q;
      assign slave_r_user_o  = r_user_q;
    end else begin : g_resp_comb
      assign rvalid_mid      = 1'b0;
      assign slave_r_valid_o = rvalid_q;
      assign slave_r_data_o  = master_r_data_i;
      assign slave_r_id_o    = master_r_id_i;
      assign slave_r_user_o  = master_r_user_i;
    end
  endgenerate

endmodule

// File: tb/tb_hci_mem_req_slice.sv
// Directed and randomized checks of hci_mem_req_slice; dut0 uses RESP_REG=0, dut1 RESP_REG=1,
// both driven by the same initiator stimulus and a 1-cycle-latency memory model.
module tb_hci_mem_req_slice;

  localparam logic [31:0] K = 32'h5A5A_A5A5;

  logic clk = 1'b0;
  logic rst_n, clr, req, we_n, mgnt;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic [7:0]  id;
  logic [0:0]  user;
  logic [31:0] m_rdata;
  logic [7:0]  m_rid;
  logic [0:0]  m_ruser;

  logic d0_gnt, d0_busy, d0_rvalid, d0_mreq, d0_mwe;
  logic [31:0] d0_rdata, d0_madd, d0_mdata;
  logic [7:0]  d0_rid, d0_mid;
  logic [0:0]  d0_ruser, d0_muser;
  logic [3:0]  d0_mbe;
  logic d1_gnt, d1_busy, d1_rvalid, d1_mreq, d1_mwe;
  logic [31:0] d1_rdata, d1_madd, d1_mdata;
  logic [7:0]  d1_rid, d1_mid;
  logic [0:0]  d1_ruser, d1_muser;
  logic [3:0]  d1_mbe;

  int checks = 0;
  int passed = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  hci_mem_req_slice #(.RESP_REG(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .busy_o(d0_busy),
    .slave_req_i(req), .slave_gnt_o(d0_gnt), .slave_add_i(add), .slave_we_n_i(we_n),
    .slave_data_i(wdata), .slave_be_i(be), .slave_id_i(id), .slave_user_i(user),
    .slave_r_data_o(d0_rdata), .slave_r_id_o(d0_rid), .slave_r_user_o(d0_ruser),
    .slave_r_valid_o(d0_rvalid), .master_req_o(d0_mreq), .master_gnt_i(mgnt),
    .master_add_o(d0_madd), .master_we_n_o(d0_mwe), .master_data_o(d0_mdata),
    .master_be_o(d0_mbe), .master_id_o(d0_mid), .master_user_o(d0_muser),
    .master_r_data_i(m_rdata), .master_r_id_i(m_rid), .master_r_user_i(m_ruser));

  hci_mem_req_slice #(.RESP_REG(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .busy_o(d1_busy),
    .slave_req_i(req), .slave_gnt_o(d1_gnt), .slave_add_i(add), .slave_we_n_i(we_n),
    .slave_data_i(wdata), .slave_be_i(be), .slave_id_i(id), .slave_user_i(user),
    .slave_r_data_o(d1_rdata), .slave_r_id_o(d1_rid), .slave_r_user_o(d1_ruser),
    .slave_r_valid_o(d1_rvalid), .master_req_o(d1_mreq), .master_gnt_i(mgnt),
    .master_add_o(d1_madd), .master_we_n_o(d1_mwe), .master_data_o(d1_mdata),
    .master_be_o(d1_mbe), .master_id_o(d1_mid), .master_user_o(d1_muser),
    .master_r_data_i(m_rdata), .master_r_id_i(m_rid), .master_r_user_i(m_ruser));

  // TCDM model: response fields valid exactly one cycle after a handshake, zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdata <= '0; m_rid <= '0; m_ruser <= '0;
    end else if (d0_mreq && mgnt) begin
      m_rdata <= d0_madd ^ K; m_rid <= d0_mid; m_ruser <= d0_muser;
    end else begin
      m_rdata <= '0; m_rid <= '0; m_ruser <= '0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1; cyc_n++;
  endtask

  task automatic idle(input int n);
    req = 1'b0; clr = 1'b0; we_n = 1'b1; mgnt = 1'b1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; req = 1'b0; we_n = 1'b1; mgnt = 1'b0;
    add = '0; wdata = '0; be = '0; id = '0; user = '0;
    #3;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if ({d0_gnt, d0_busy, d0_rvalid, d0_mreq, d0_mwe, d0_madd, d0_mdata, d0_mbe, d0_mid, d0_muser,
           d0_rdata, d0_rid, d0_ruser} !== '0)
        $display("FAIL reset_d0[%0d] outputs nonzero gnt=%b req=%b add=%h", r, d0_gnt, d0_mreq, d0_madd);
      else passed++;
      checks++;
      if ({d1_gnt, d1_busy, d1_rvalid, d1_mreq, d1_mwe, d1_madd, d1_mdata, d1_mbe, d1_mid, d1_muser,
           d1_rdata, d1_rid, d1_ruser} !== '0)
        $display("FAIL reset_d1[%0d] outputs nonzero gnt=%b req=%b add=%h", r, d1_gnt, d1_mreq, d1_madd);
      else passed++;
      cyc();
    end
    rst_n = 1'b1; #1;
    checks++; if (d0_gnt !== 1'b0) $display("FAIL reset_gnt_before_edge got=%b exp=0", d0_gnt); else passed++;
    cyc();
    checks++; if (d0_gnt !== 1'b1) $display("FAIL reset_gnt_after_edge got=%b exp=1", d0_gnt); else passed++;
    checks++; if (d0_mreq !== 1'b0 || d0_busy !== 1'b0)
      $display("FAIL reset_idle got req=%b busy=%b exp 0 0", d0_mreq, d0_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] base = 32'h1000_0000;
    bit ex;
    for (int k = 0; k < 12; k++) begin
      cyc();
      req = (k < 8); add = base + 32'(k * 4); id = 8'h10 + 8'(k); we_n = 1'b1; mgnt = 1'b1;
      #1;
      if (k < 8) begin
        checks++; if (d0_gnt !== 1'b1) $display("FAIL b2b_gnt[%0d] got=%b exp=1", k, d0_gnt); else passed++;
      end
      ex = (k >= 1 && k <= 8);
      checks++; if (d0_mreq !== ex) $display("FAIL b2b_mreq[%0d] got=%b exp=%b", k, d0_mreq, ex); else passed++;
      if (ex) begin
        checks++; if (d0_madd !== base + 32'((k - 1) * 4))
          $display("FAIL b2b_madd[%0d] got=%h exp=%h", k, d0_madd, base + 32'((k - 1) * 4)); else passed++;
      end
      ex = (k >= 2 && k <= 9);
      checks++; if (d0_rvalid !== ex) $display("FAIL b2b_rvalid0[%0d] got=%b exp=%b", k, d0_rvalid, ex); else passed++;
      if (ex) begin
        checks++; if (d0_rid !== 8'h10 + 8'(k - 2) || d0_rdata !== ((base + 32'((k - 2) * 4)) ^ K))
          $display("FAIL b2b_rid0[%0d] got=%h/%h exp=%h", k, d0_rid, d0_rdata, 8'h10 + 8'(k - 2)); else passed++;
      end
      ex = (k >= 3 && k <= 10);
      checks++; if (d1_rvalid !== ex) $display("FAIL b2b_rvalid1[%0d] got=%b exp=%b", k, d1_rvalid, ex); else passed++;
      if (ex) begin
        checks++; if (d1_rid !== 8'h10 + 8'(k - 3))
          $display("FAIL b2b_rid1[%0d] got=%h exp=%h", k, d1_rid, 8'h10 + 8'(k - 3)); else passed++;
      end
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [31:0] b0 = 32'h2000_0000, b1 = 32'h2000_0004, b2 = 32'h2000_0008;
    cyc(); req = 1'b1; add = b0; id = 8'h20; mgnt = 1'b0; #1;
    checks++; if (d0_gnt !== 1'b1 || d0_mreq !== 1'b0) $display("FAIL bp_c0 got gnt=%b req=%b exp 1 0", d0_gnt, d0_mreq); else passed++;
    cyc(); add = b1; id = 8'h21; #1;
    checks++; if (d0_gnt !== 1'b1 || d0_mreq !== 1'b1 || d0_madd !== b0)
      $display("FAIL bp_c1 got gnt=%b req=%b add=%h exp 1 1 %h", d0_gnt, d0_mreq, d0_madd, b0); else passed++;
    cyc(); add = b2; id = 8'h22; #1;
    checks++; if (d0_gnt !== 1'b0 || d0_madd !== b0) $display("FAIL bp_full got gnt=%b add=%h exp 0 %h", d0_gnt, d0_madd, b0); else passed++;
    cyc(); mgnt = 1'b1; #1;
    checks++; if (d0_gnt !== 1'b0 || d0_mreq !== 1'b1 || d0_madd !== b0)
      $display("FAIL bp_stable got gnt=%b req=%b add=%h exp 0 1 %h", d0_gnt, d0_mreq, d0_madd, b0); else passed++;
    cyc(); #1;
    checks++; if (d0_gnt !== 1'b1 || d0_madd !== b1) $display("FAIL bp_gnt_back got gnt=%b add=%h exp 1 %h", d0_gnt, d0_madd, b1); else passed++;
    checks++; if (d0_rvalid !== 1'b1 || d0_rid !== 8'h20) $display("FAIL bp_r0 got v=%b id=%h exp 1 20", d0_rvalid, d0_rid); else passed++;
    cyc(); req = 1'b0; #1;
    checks++; if (d0_mreq !== 1'b1 || d0_madd !== b2) $display("FAIL bp_b2 got req=%b add=%h exp 1 %h", d0_mreq, d0_madd, b2); else passed++;
    checks++; if (d0_rvalid !== 1'b1 || d0_rid !== 8'h21) $display("FAIL bp_r1 got v=%b id=%h exp 1 21", d0_rvalid, d0_rid); else passed++;
    cyc(); #1;
    checks++; if (d0_mreq !== 1'b0 || d0_rvalid !== 1'b1 || d0_rid !== 8'h22)
      $display("FAIL bp_r2 got req=%b v=%b id=%h exp 0 1 22", d0_mreq, d0_rvalid, d0_rid); else passed++;
    cyc(); #1;
    checks++; if (d0_rvalid !== 1'b0 || d0_busy !== 1'b0) $display("FAIL bp_idle got v=%b busy=%b exp 0 0", d0_rvalid, d0_busy); else passed++;
    idle(2);
  endtask

  task automatic test_write();
    cyc(); req = 1'b1; we_n = 1'b0; add = 32'h3000_0040; wdata = 32'hDEAD_BEEF; be = 4'b0101;
    id = 8'h3C; user = 1'b1; mgnt = 1'b1; #1;
    checks++; if (d0_gnt !== 1'b1) $display("FAIL wr_gnt got=%b exp=1", d0_gnt); else passed++;
    cyc(); req = 1'b0; we_n = 1'b1; wdata = '0; be = '0; user = 1'b0; #1;
    checks++; if (d0_mreq !== 1'b1 || d0_madd !== 32'h3000_0040 || d0_mwe !== 1'b0)
      $display("FAIL wr_req got req=%b add=%h we_n=%b", d0_mreq, d0_madd, d0_mwe); else passed++;
    checks++; if (d0_mdata !== 32'hDEAD_BEEF || d0_mbe !== 4'b0101 || d0_mid !== 8'h3C || d0_muser !== 1'b1)
      $display("FAIL wr_fields got data=%h be=%b id=%h user=%b exp deadbeef 0101 3c 1", d0_mdata, d0_mbe, d0_mid, d0_muser);
    else passed++;
    cyc(); #1;
    checks++; if (d0_rvalid !== 1'b1 || d0_rid !== 8'h3C || d0_ruser !== 1'b1)
      $display("FAIL wr_resp got v=%b id=%h user=%b exp 1 3c 1", d0_rvalid, d0_rid, d0_ruser); else passed++;
    idle(3);
  endtask

  task automatic test_clear();
    cyc(); req = 1'b1; add = 32'h4000_0000; id = 8'h41; mgnt = 1'b0; #1;
    checks++; if (d0_gnt !== 1'b1) $display("FAIL clr_c0_gnt got=%b exp=1", d0_gnt); else passed++;
    cyc(); add = 32'h4000_0004; id = 8'h42; mgnt = 1'b1; #1;
    checks++; if (d0_mreq !== 1'b1 || d0_madd !== 32'h4000_0000) $display("FAIL clr_pop got req=%b add=%h", d0_mreq, d0_madd); else passed++;
    cyc(); add = 32'h4000_0008; id = 8'h43; mgnt = 1'b0; #1;
    checks++; if (d0_madd !== 32'h4000_0004 || d0_rvalid !== 1'b1 || d0_rid !== 8'h41)
      $display("FAIL clr_c2 got add=%h v=%b id=%h", d0_madd, d0_rvalid, d0_rid); else passed++;
    cyc(); clr = 1'b1; mgnt = 1'b1; add = 32'h4000_000C; id = 8'h44; #1;
    checks++; if (d0_gnt !== 1'b0 || d0_mreq !== 1'b0) $display("FAIL clr_gate got gnt=%b req=%b exp 0 0", d0_gnt, d0_mreq); else passed++;
    checks++; if (d1_rvalid !== 1'b1 || d1_rid !== 8'h41 || d0_busy !== 1'b1)
      $display("FAIL clr_resp got v1=%b id1=%h busy=%b exp 1 41 1", d1_rvalid, d1_rid, d0_busy); else passed++;
    cyc(); clr = 1'b0; req = 1'b0; #1;
    checks++; if (d0_mreq !== 1'b0 || d0_rvalid !== 1'b0 || d0_busy !== 1'b0 || d0_gnt !== 1'b1)
      $display("FAIL clr_after got req=%b v=%b busy=%b gnt=%b exp 0 0 0 1", d0_mreq, d0_rvalid, d0_busy, d0_gnt); else passed++;
    idle(2);
  endtask

  task automatic test_resp_reg();
    cyc(); req = 1'b1; add = 32'h486E_F3DD; id = 8'h55; mgnt = 1'b1; #1;
    cyc(); req = 1'b0; #1;
    checks++; if (d1_mreq !== 1'b1) $display("FAIL rr_pop got=%b exp=1", d1_mreq); else passed++;
    cyc(); #1;
    checks++; if (d1_rvalid !== 1'b0 || d1_busy !== 1'b1) $display("FAIL rr_m1 got v=%b busy=%b exp 0 1", d1_rvalid, d1_busy); else passed++;
    cyc(); #1;
    checks++; if (d1_rvalid !== 1'b1 || d1_rdata !== 32'h1234_5678 || d1_rid !== 8'h55 || d1_busy !== 1'b1)
      $display("FAIL rr_m2 got v=%b data=%h id=%h busy=%b exp 1 12345678 55 1", d1_rvalid, d1_rdata, d1_rid, d1_busy); else passed++;
    cyc(); #1;
    checks++; if (d1_rvalid !== 1'b0 || d1_busy !== 1'b0 || d1_rdata !== 32'h1234_5678)
      $display("FAIL rr_m3 got v=%b busy=%b data=%h exp 0 0 12345678", d1_rvalid, d1_busy, d1_rdata); else passed++;
    idle(2);
  endtask

  // Scoreboard queues for the randomized run
  logic [7:0]  q_id[$];
  logic [31:0] q_add[$];
  logic [7:0]  r0_id[$];
  logic [31:0] r0_dat[$];
  logic [7:0]  r1_id[$];
  logic [31:0] r1_dat[$];
  int          r1_due[$];
  logic [7:0]  seq_id = 8'h80;

  task automatic step_rand(input bit active);
    bit ex;
    cyc();
    ex = (r0_id.size() != 0);
    checks++; if (d0_rvalid !== ex) $display("FAIL rnd_rvalid0 cyc=%0d got=%b exp=%b", cyc_n, d0_rvalid, ex); else passed++;
    if (ex) begin
      checks++; if (d0_rid !== r0_id[0] || d0_rdata !== r0_dat[0])
        $display("FAIL rnd_resp0 cyc=%0d got=%h/%h exp=%h/%h", cyc_n, d0_rid, d0_rdata, r0_id[0], r0_dat[0]); else passed++;
      void'(r0_id.pop_front()); void'(r0_dat.pop_front());
    end
    ex = (r1_due.size() != 0) && (r1_due[0] == cyc_n);
    checks++; if (d1_rvalid !== ex) $display("FAIL rnd_rvalid1 cyc=%0d got=%b exp=%b", cyc_n, d1_rvalid, ex); else passed++;
    if (ex) begin
      checks++; if (d1_rid !== r1_id[0] || d1_rdata !== r1_dat[0])
        $display("FAIL rnd_resp1 cyc=%0d got=%h/%h exp=%h/%h", cyc_n, d1_rid, d1_rdata, r1_id[0], r1_dat[0]); else passed++;
      void'(r1_id.pop_front()); void'(r1_dat.pop_front()); void'(r1_due.pop_front());
    end
    req   = active && ($urandom_range(3) != 0);
    add   = $urandom; wdata = $urandom; be = 4'($urandom); user = 1'($urandom);
    we_n  = 1'($urandom); id = seq_id; seq_id = seq_id + 8'd1;
    mgnt  = active ? ($urandom_range(2) != 0) : 1'b1;
    clr   = active && ($urandom_range(24) == 0);
    #1;
    if (clr) begin
      checks++; if (d0_gnt !== 1'b0 || d0_mreq !== 1'b0) $display("FAIL rnd_clr got gnt=%b req=%b exp 0 0", d0_gnt, d0_mreq); else passed++;
    end
    if (d0_mreq && mgnt) begin
      checks++;
      if (q_id.size() == 0) $display("FAIL rnd_dup cyc=%0d issued id=%h with empty scoreboard", cyc_n, d0_mid);
      else if (d0_mid !== q_id[0] || d0_madd !== q_add[0])
        $display("FAIL rnd_order cyc=%0d got=%h/%h exp=%h/%h", cyc_n, d0_mid, d0_madd, q_id[0], q_add[0]);
      else passed++;
      if (q_id.size() != 0) begin
        r0_id.push_back(q_id[0]); r0_dat.push_back(q_add[0] ^ K);
        r1_id.push_back(q_id[0]); r1_dat.push_back(q_add[0] ^ K); r1_due.push_back(cyc_n + 2);
        void'(q_id.pop_front()); void'(q_add.pop_front());
      end
    end
    if (req && d0_gnt) begin
      q_id.push_back(id); q_add.push_back(add);
    end
    if (clr) begin
      q_id.delete(); q_add.delete();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 30) begin
        cyc(); req = 1'b0; clr = 1'b0; #2; rst_n = 1'b0; #1;
        checks++;
        if ({d0_gnt, d0_busy, d0_rvalid, d0_mreq, d0_madd, d0_mid, d0_rdata, d0_rid,
             d1_gnt, d1_busy, d1_rvalid, d1_mreq, d1_madd, d1_mid, d1_rdata, d1_rid} !== '0)
          $display("FAIL rnd_async_reset outputs nonzero gnt=%b req=%b v=%b", d0_gnt, d0_mreq, d0_rvalid);
        else passed++;
        q_id.delete(); q_add.delete(); r0_id.delete(); r0_dat.delete();
        r1_id.delete(); r1_dat.delete(); r1_due.delete();
        cyc(); rst_n = 1'b1;
      end else begin
        step_rand(1'b1);
      end
    end
    for (int i = 0; i < 6; i++) step_rand(1'b0);
    checks++;
    if (q_id.size() != 0 || r0_id.size() != 0 || r1_id.size() != 0)
      $display("FAIL rnd_loss pending req=%0d r0=%0d r1=%0d exp 0 0 0", q_id.size(), r0_id.size(), r1_id.size());
    else passed++;
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_write();
    test_clear();
    test_resp_reg();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
